// File: rtl/button_conditioner.sv
// Button input stage: two-flop synchroniser, per-channel debounce, press/release edge pulses
// and a typematic move strobe, so a held button produces steady paddle motion.
module button_conditioner #(
  parameter int NUM_BUTTONS       = 4,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY      = 25_000_000,
  parameter int REPEAT_PERIOD     = 5_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_move
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W    = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
  localparam logic [RC_W-1:0] RC_ONE      = RC_W'(1);

  // Sync flops reset to the raw pin value meaning "not pressed".
  localparam logic [NUM_BUTTONS-1:0] RAW_IDLE = {NUM_BUTTONS{BUTTON_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic [NUM_BUTTONS-1:0] sync1_reg;
  logic [NUM_BUTTONS-1:0] sync2_reg;
  logic [NUM_BUTTONS-1:0] btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= RAW_IDLE;
      sync2_reg <= RAW_IDLE;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_sync = BUTTON_ACTIVE_LOW ? ~sync2_reg : sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      logic            level_reg, level_next;
      logic            prev_reg;
      logic            press_reg;
      logic            release_reg;
      logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
      rpt_state_t      state_reg, state_next;
      logic [RC_W-1:0] rcnt_reg, rcnt_next;
      logic            move_reg, move_next;
      logic            rise;
      logic            fall;

      // Any sample that agrees with the accepted level restarts the stability count.
      always_comb begin
        db_cnt_next = '0;
        level_next  = level_reg;
        if (btn_sync[gi] != level_reg) begin
          if (db_cnt_reg == DB_LAST) begin
            level_next = ~level_reg;
          end else begin
            db_cnt_next = db_cnt_reg + DB_ONE;
          end
        end
      end

      assign rise = level_reg & ~prev_reg;
      assign fall = ~level_reg & prev_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt_reg  <= '0;
          level_reg   <= 1'b0;
          prev_reg    <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          db_cnt_reg  <= db_cnt_next;
          level_reg   <= level_next;
          prev_reg    <= level_reg;
          press_reg   <= rise;
          release_reg <= fall;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          rcnt_reg  <= '0;
          move_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          rcnt_reg  <= rcnt_next;
          move_reg  <= move_next;
        end
      end

      // A released level forces IDLE ahead of any strobe that happens to be due.
      always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        if (!level_reg) begin
          state_next = IDLE;
          rcnt_next  = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              rcnt_next = '0;
              if (rise) state_next = HOLD;
            end
            HOLD: begin
              if (rcnt_reg == DELAY_LAST) begin
                state_next = REPEAT;
                rcnt_next  = '0;
              end else begin
                rcnt_next = rcnt_reg + RC_ONE;
              end
            end
            REPEAT: begin
              if (rcnt_reg == PERIOD_LAST) rcnt_next = '0;
              else                         rcnt_next = rcnt_reg + RC_ONE;
            end
            default: begin
              state_next = IDLE;
              rcnt_next  = '0;
            end
          endcase
        end
      end

      always_comb begin
        move_next = 1'b0;
        if (level_reg) begin
          case (state_reg)
            IDLE:    move_next = rise;
            HOLD:    move_next = (rcnt_reg == DELAY_LAST);
            REPEAT:  move_next = (rcnt_reg == PERIOD_LAST);
            default: move_next = 1'b0;
          endcase
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_move[gi]    = move_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing;
// expected waveforms are written as functions of the edge count since each stimulus change.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_move;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NUM_BUTTONS       (4),
    .BUTTON_ACTIVE_LOW (1'b1),
    .DEBOUNCE_CYCLES   (4),
    .REPEAT_DELAY      (10),
    .REPEAT_PERIOD     (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_move    (btn_move)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All pins pressed through reset; accepted 6 edges after deassert, then released.
  task automatic test_reset();
    logic [3:0] el, ep, er, em;
    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got l=%b p=%b r=%b m=%b required all 0",
                 i, btn_level, btn_press, btn_release, btn_move);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      el = (e >= 6 && e < 14) ? 4'hF : 4'h0;
      ep = (e == 7) ? 4'hF : 4'h0;
      er = (e == 15) ? 4'hF : 4'h0;
      em = (e == 7) ? 4'hF : 4'h0;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== {el, ep, er, em}) begin
        errors++;
        $display("FAIL reset_accept e=%0d got l=%b p=%b r=%b m=%b required l=%b p=%b r=%b m=%b",
                 e, btn_level, btn_press, btn_release, btn_move, el, ep, er, em);
      end
      if (e == 8) btn_raw = 4'hF;
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btn_raw[0] = (i < 3 || (i >= 4 && i < 7)) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== 16'h0000) begin
        errors++;
        $display("FAIL bounce i=%0d got l=%b p=%b r=%b m=%b required all 0",
                 i, btn_level, btn_press, btn_release, btn_move);
      end
    end
    $display("test_bounce done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep, er, em;
    btn_raw[1] = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      el = (e >= 6 && e < 14) ? 4'b0010 : 4'b0000;
      ep = (e == 7) ? 4'b0010 : 4'b0000;
      er = (e == 15) ? 4'b0010 : 4'b0000;
      em = (e == 7) ? 4'b0010 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== {el, ep, er, em}) begin
        errors++;
        $display("FAIL clean_press e=%0d got l=%b p=%b r=%b m=%b required l=%b p=%b r=%b m=%b",
                 e, btn_level, btn_press, btn_release, btn_move, el, ep, er, em);
      end
      if (e == 8) btn_raw[1] = 1'b1;
    end
    $display("test_clean_press done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Strobes at press (edge 7), +10, then every 3; release lands between strobes.
  task automatic test_typematic();
    logic [3:0] el, ep, er, em;
    btn_raw[2] = 1'b0;
    for (int e = 1; e <= 52; e++) begin
      tick();
      el = (e >= 6 && e < 44) ? 4'b0100 : 4'b0000;
      ep = (e == 7) ? 4'b0100 : 4'b0000;
      er = (e == 45) ? 4'b0100 : 4'b0000;
      em = (e == 7 || (e >= 17 && e <= 44 && (e - 17) % 3 == 0)) ? 4'b0100 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== {el, ep, er, em}) begin
        errors++;
        $display("FAIL typematic e=%0d got l=%b p=%b r=%b m=%b required l=%b p=%b r=%b m=%b",
                 e, btn_level, btn_press, btn_release, btn_move, el, ep, er, em);
      end
      if (e == 38) btn_raw[2] = 1'b1;
    end
    $display("test_typematic done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Level falls at edge 22; the strobe due at edge 23 is suppressed by the release.
  task automatic test_release_vs_strobe();
    logic [3:0] el, ep, er, em;
    btn_raw[3] = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      el = (e >= 6 && e < 22) ? 4'b1000 : 4'b0000;
      ep = (e == 7) ? 4'b1000 : 4'b0000;
      er = (e == 23) ? 4'b1000 : 4'b0000;
      em = (e == 7 || e == 17 || e == 20) ? 4'b1000 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== {el, ep, er, em}) begin
        errors++;
        $display("FAIL release_vs_strobe e=%0d got l=%b p=%b r=%b m=%b required l=%b p=%b r=%b m=%b",
                 e, btn_level, btn_press, btn_release, btn_move, el, ep, er, em);
      end
      if (e == 16) btn_raw[3] = 1'b1;
    end
    $display("test_release_vs_strobe done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    logic [3:0] el, ep, er, em;
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      el = (e >= 6) ? 4'b0001 : 4'b0000;
      ep = (e == 7) ? 4'b0001 : 4'b0000;
      er = 4'b0000;
      em = (e == 7 || e == 17 || e == 20) ? 4'b0001 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== {el, ep, er, em}) begin
        errors++;
        $display("FAIL async_pre e=%0d got l=%b p=%b r=%b m=%b required l=%b p=%b r=%b m=%b",
                 e, btn_level, btn_press, btn_release, btn_move, el, ep, er, em);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_move} !== 16'h0000) begin
      errors++;
      $display("FAIL async_assert got l=%b p=%b r=%b m=%b required all 0",
               btn_level, btn_press, btn_release, btn_move);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      tick();
      el = (e >= 6) ? 4'b0001 : 4'b0000;
      ep = (e == 7) ? 4'b0001 : 4'b0000;
      er = 4'b0000;
      em = (e == 7 || e == 17 || e == 20) ? 4'b0001 : 4'b0000;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_move} !== {el, ep, er, em}) begin
        errors++;
        $display("FAIL async_post e=%0d got l=%b p=%b r=%b m=%b required l=%b p=%b r=%b m=%b",
                 e, btn_level, btn_press, btn_release, btn_move, el, ep, er, em);
      end
    end
    btn_raw = 4'hF;
    for (int i = 0; i < 12; i++) tick();
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'h0;
    test_reset();
    test_bounce();
    test_clean_press();
    test_typematic();
    test_release_vs_strobe();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
